// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU opcode encodings used by the ALU, the ALU control unit and the
// multi-cycle multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_MUL    = 5'b01010;
    localparam logic [4:0] ALU_MULH   = 5'b01011;
    localparam logic [4:0] ALU_MULHSU = 5'b01100;
    localparam logic [4:0] ALU_MULHU  = 5'b01101;
    localparam logic [4:0] ALU_DIV    = 5'b01110;
    localparam logic [4:0] ALU_DIVU   = 5'b01111;
    localparam logic [4:0] ALU_REM    = 5'b10000;
    localparam logic [4:0] ALU_REMU   = 5'b10001;

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit: one step per cycle over magnitudes,
// sign correction in FIX, one-cycle shortcut for divide-by-zero and overflow.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [4:0]         i_alu_op,
    input  logic [NB_DATA-1:0] i_op_a,
    input  logic [NB_DATA-1:0] i_op_b,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_stall,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [5:0]         LAST_ITER = 6'(NB_DATA - 1);
    localparam logic [NB_DATA-1:0] ALL_ONES  = {NB_DATA{1'b1}};
    localparam logic [NB_DATA-1:0] ZERO      = {NB_DATA{1'b0}};
    localparam logic [NB_DATA-1:0] MIN_NEG   = {1'b1, {(NB_DATA-1){1'b0}}};

    state_t             state_r;
    logic [4:0]         op_r;
    logic [NB_DATA-1:0] hi_r, lo_r, b_r, result_r;
    logic               neg_r, busy_r, done_r;
    logic [5:0]         cnt_r;

    logic               idle_like_s, accept_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic               div_zero_s, ovf_s, special_s, neg_flag_s, take_s;
    logic [NB_DATA-1:0] a_mag_s, b_mag_s, special_res_s, fix_res_s;
    logic [NB_DATA-1:0] quo_fix_s, rem_fix_s;
    logic [NB_DATA:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic [2*NB_DATA-1:0] prod_fix_s;

    // Acceptance decode: operand signedness, magnitudes and one-cycle special cases
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (i_alu_op)
            ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            ALU_MULHSU: a_signed_s = 1'b1;
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
        accept_s    = idle_like_s && i_start && is_muldiv_op(i_alu_op);
        a_neg_s     = a_signed_s && i_op_a[NB_DATA-1];
        b_neg_s     = b_signed_s && i_op_b[NB_DATA-1];
        a_mag_s     = a_neg_s ? (ZERO - i_op_a) : i_op_a;
        b_mag_s     = b_neg_s ? (ZERO - i_op_b) : i_op_b;
        neg_flag_s  = is_rem_op(i_alu_op) ? a_neg_s : (a_neg_s ^ b_neg_s);
        div_zero_s  = is_div_op(i_alu_op) && (i_op_b == ZERO);
        ovf_s       = ((i_alu_op == ALU_DIV) || (i_alu_op == ALU_REM)) &&
                      (i_op_a == MIN_NEG) && (i_op_b == ALL_ONES);
        special_s   = div_zero_s || ovf_s;
        if (div_zero_s) begin
            special_res_s = is_rem_op(i_alu_op) ? i_op_a : ALL_ONES;
        end else if (ovf_s) begin
            special_res_s = is_rem_op(i_alu_op) ? ZERO : MIN_NEG;
        end else begin
            special_res_s = ZERO;
        end
    end

    // One radix-2 step: shift-add product in {hi,lo}, or restoring divide with remainder in hi
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(NB_DATA+1){1'b0}});
        div_shift_s = {hi_r, lo_r[NB_DATA-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        take_s      = ~div_diff_s[NB_DATA];
    end

    // Sign correction and result selection used on the FIX -> DONE edge
    always_comb begin
        prod_fix_s = neg_r ? ({(2*NB_DATA){1'b0}} - {hi_r, lo_r}) : {hi_r, lo_r};
        quo_fix_s  = neg_r ? (ZERO - lo_r) : lo_r;
        rem_fix_s  = neg_r ? (ZERO - hi_r) : hi_r;
        case (op_r)
            ALU_MUL:                         fix_res_s = prod_fix_s[NB_DATA-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res_s = prod_fix_s[2*NB_DATA-1:NB_DATA];
            ALU_DIV, ALU_DIVU:               fix_res_s = quo_fix_s;
            ALU_REM, ALU_REMU:               fix_res_s = rem_fix_s;
            default:                         fix_res_s = ZERO;
        endcase
    end

    // Sequencer FSM with datapath registers and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= 5'd0;
            hi_r     <= ZERO;
            lo_r     <= ZERO;
            b_r      <= ZERO;
            neg_r    <= 1'b0;
            cnt_r    <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO;
        end else if (i_flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        op_r  <= i_alu_op;
                        neg_r <= neg_flag_s;
                        cnt_r <= 6'd0;
                        hi_r  <= ZERO;
                        lo_r  <= a_mag_s;
                        b_r   <= b_mag_s;
                        if (special_s) begin
                            state_r  <= ST_DONE;
                            done_r   <= 1'b1;
                            result_r <= special_res_s;
                        end else begin
                            state_r <= ST_CALC;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (is_div_op(op_r)) begin
                        hi_r <= take_s ? div_diff_s[NB_DATA-1:0] : div_shift_s[NB_DATA-1:0];
                        lo_r <= {lo_r[NB_DATA-2:0], take_s};
                    end else begin
                        hi_r <= mul_sum_s[NB_DATA:1];
                        lo_r <= {mul_sum_s[0], lo_r[NB_DATA-1:1]};
                    end
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == LAST_ITER) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    state_r  <= ST_DONE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    result_r <= fix_res_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = busy_r;
    assign o_done   = done_r;
    assign o_result = result_r;
    assign o_stall  = busy_r || accept_s;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed table-driven bench for muldiv_sequencer plus hand-written
// flush, reset, illegal-opcode and back-to-back sequences.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [4:0]  i_alu_op = 5'd0;
    logic [31:0] i_op_a = 32'd0;
    logic [31:0] i_op_b = 32'd0;
    logic        i_flush = 1'b0;
    logic        o_busy, o_stall, o_done;
    logic [31:0] o_result;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_sequencer #(.NB_DATA(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_alu_op(i_alu_op),
        .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush),
        .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge just after the accepting edge; lat counts edges from start to o_done
    task automatic wait_done(output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (!o_done && lat < 100) begin
            if (o_busy) busy_n++;
            @(posedge i_clk);
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge i_clk);
            if (o_done) seen++;
        end
    endtask

    initial begin
        int lat, busy_n, seen;
        logic [31:0] last_exp;

        vecs[0]  = '{ALU_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
        vecs[1]  = '{ALU_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[2]  = '{ALU_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
        vecs[3]  = '{ALU_REM,    32'h00000007, 32'h00000000, 32'h00000007, 1};
        vecs[4]  = '{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[5]  = '{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[6]  = '{ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[7]  = '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[8]  = '{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[9]  = '{ALU_MUL,    32'h00000003, 32'hFFFFFFFC, 32'hFFFFFFF4, 34};
        vecs[10] = '{ALU_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 34};
        vecs[11] = '{ALU_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 34};
        vecs[12] = '{ALU_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 34};
        vecs[13] = '{ALU_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[14] = '{ALU_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34};
        vecs[15] = '{ALU_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 34};

        #1;
        check("reset_busy",   {31'd0, o_busy},  32'd0);
        check("reset_done",   {31'd0, o_done},  32'd0);
        check("reset_result", o_result,         32'd0);
        check("reset_stall",  {31'd0, o_stall}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 16; i++) begin
            i_start = 1'b1; i_alu_op = vecs[i].op; i_op_a = vecs[i].a; i_op_b = vecs[i].b;
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            wait_done(lat, busy_n);
            check($sformatf("vec%0d_result", i), o_result, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, (vecs[i].lat == 34) ? 33 : 0);
            @(negedge i_clk);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, o_done}, 32'd0);
        end
        last_exp = vecs[15].exp;

        // Flush at CALC iteration 10
        i_start = 1'b1; i_alu_op = ALU_DIVU; i_op_a = 32'd100; i_op_b = 32'd7;
        #1;
        check("stall_on_valid_start", {31'd0, o_stall}, 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        check("busy_mid_calc", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_busy",   {31'd0, o_busy},  32'd0);
        check("flush_done",   {31'd0, o_done},  32'd0);
        check("flush_stall",  {31'd0, o_stall}, 32'd0);
        check("flush_result", o_result, last_exp);
        count_done(40, seen);
        check("flush_no_done", seen, 32'd0);
        check("flush_result_held", o_result, last_exp);

        // Non-M opcode start is ignored
        i_start = 1'b1; i_alu_op = ALU_ADD; i_op_a = 32'd1; i_op_b = 32'd2;
        #1;
        check("add_stall", {31'd0, o_stall}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        check("add_busy",   {31'd0, o_busy}, 32'd0);
        check("add_done",   {31'd0, o_done}, 32'd0);
        check("add_result", o_result, last_exp);

        // Reset mid-CALC clears outputs immediately
        i_start = 1'b1; i_alu_op = ALU_MUL; i_op_a = 32'd5; i_op_b = 32'd6;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_busy",   {31'd0, o_busy},  32'd0);
        check("rst_done",   {31'd0, o_done},  32'd0);
        check("rst_result", o_result,         32'd0);
        check("rst_stall",  {31'd0, o_stall}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        count_done(40, seen);
        check("rst_no_done", seen, 32'd0);

        // Back-to-back: special case lands in DONE, next start accepted from DONE
        i_start = 1'b1; i_alu_op = ALU_DIVU; i_op_a = 32'd5; i_op_b = 32'd0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("b2b_first_done",   {31'd0, o_done}, 32'd1);
        check("b2b_first_result", o_result, 32'hFFFFFFFF);
        i_alu_op = ALU_MUL; i_op_a = 32'd3; i_op_b = 32'hFFFFFFFC;
        #1;
        check("b2b_stall_in_done", {31'd0, o_stall}, 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        check("b2b_busy",        {31'd0, o_busy}, 32'd1);
        check("b2b_done_low",    {31'd0, o_done}, 32'd0);
        check("b2b_result_held", o_result, 32'hFFFFFFFF);
        wait_done(lat, busy_n);
        check("b2b_result",  o_result, 32'hFFFFFFF4);
        check("b2b_latency", lat, 32'd34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, the operand/result width in bits.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_start  input  1  request to start a multi-cycle operation.
REQ-005 SHALL have port i_alu_op  input  5  ALU operation code from ALU control unit.
REQ-006 SHALL have port i_op_a  input  NB_DATA  operand A (rs1).
REQ-007 SHALL have port i_op_b  input  NB_DATA  operand B (rs2).
REQ-008 SHALL have port i_flush  input  1  abort the in-flight operation.
REQ-009 SHALL have port o_busy  output  1  registered; high in states CALC and FIX.
REQ-010 SHALL have port o_stall  output  1  combinational pipeline stall request.
REQ-011 SHALL have port o_done  output  1  registered one-cycle completion pulse.
REQ-012 SHALL have port o_result  output  NB_DATA  registered result, held until the next completion.

Function
REQ-013 SHALL accept i_start only in IDLE or DONE and only when i_alu_op is MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU (5'b01010-5'b10001); all other codes and starts in CALC/FIX are ignored.
REQ-014 SHALL implement states IDLE, CALC, FIX, DONE: IDLE/DONE -accept-> CALC (or DONE for special cases); CALC -32nd iteration-> FIX; FIX -> DONE; DONE -> IDLE unless a new start is accepted.
REQ-015 SHALL, on acceptance, latch opcode, operand magnitudes (abs value for signed operands) and result-sign flags, and clear a 6-bit iteration counter.
REQ-016 SHALL, in CALC, perform one radix-2 step per cycle: shift-add over a 2*NB_DATA product for multiplies, restoring shift-subtract for divides.
REQ-017 SHALL, in FIX, two's-complement the product, quotient or remainder when its sign flag is set (remainder takes dividend sign).
REQ-018 SHALL select o_result: MUL low half; MULH/MULHSU/MULHU high half (signed*signed, signed*unsigned, unsigned*unsigned); DIV/DIVU quotient; REM/REMU remainder.
REQ-019 SHALL assert o_done exactly 34 cycles after the accepting edge for normal operations (32 CALC + FIX + DONE).
REQ-020 SHALL handle divide-by-zero in 1 cycle (IDLE->DONE): quotient all ones, remainder = i_op_a.
REQ-021 SHALL handle signed overflow (DIV/REM, A = 0x80000000, B = 0xFFFFFFFF) in 1 cycle: quotient 0x80000000, remainder 0.
REQ-022 SHALL drive o_stall = o_busy OR (i_start AND valid M-opcode AND state in IDLE/DONE).
REQ-023 SHALL, on i_flush in any state, return to IDLE at the next edge with no o_done and o_result unchanged; i_flush has priority over a simultaneous i_start.
REQ-024 SHALL keep o_result stable except on the edge entering DONE.

Reset
REQ-025 SHALL, while i_rst_n is low, force state IDLE, counter 0, o_busy 0, o_done 0, o_result 0, all internal registers 0, regardless of the clock.
REQ-026 SHALL abort any in-flight operation on reset, with no o_done after deassertion.

Structure
REQ-027 SHALL take ALU opcode localparams from a shared alu_ops include used by ALU, ALU control unit and this block; state encoding stays local.
REQ-028 SHALL be a single module with no sub-modules; the datapath is the iterative accumulator/remainder registers.

Verification
REQ-029 SHALL verify DIV A=0xFFFFFFF9 (-7) B=2 -> o_result 0xFFFFFFFD, REM -> 0xFFFFFFFF, o_done 34 cycles after start, o_busy high 33 cycles.
REQ-030 SHALL verify DIVU 5/0 -> 0xFFFFFFFF and REM 7/0 -> 7, each with o_done one cycle after start.
REQ-031 SHALL verify DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, one-cycle latency.
REQ-032 SHALL verify MULH 0x80000000*0x80000000 -> 0x40000000, MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF, MUL 3*-4 -> 0xFFFFFFF4.
REQ-033 SHALL verify i_flush at CALC iteration 10 -> IDLE next edge, no o_done, o_result unchanged; i_start with ALU_ADD -> no state change, o_stall 0.
REQ-034 SHALL verify i_rst_n low mid-CALC -> all outputs 0 immediately; back-to-back start in DONE -> new operation accepted without an IDLE cycle.
